// File: rtl/scarv_cop_palu_multiplier_pkg.sv
// Shared constants for the COP packed-arithmetic multiplier.
// Holds the pack-width encodings, the lane-width-minus-one lookup and the
// multiplier state encoding. Both the multiplier and the packed adder use
// the lookup helpers, so they always agree on where lane boundaries fall.
package scarv_cop_palu_multiplier_pkg;

   // Pack-width encodings used across the COP.
   localparam logic [2:0] SCARV_COP_PW_1  = 3'b001;
   localparam logic [2:0] SCARV_COP_PW_2  = 3'b010;
   localparam logic [2:0] SCARV_COP_PW_4  = 3'b011;
   localparam logic [2:0] SCARV_COP_PW_8  = 3'b100;
   localparam logic [2:0] SCARV_COP_PW_16 = 3'b101;

   // Lane width minus one for each pack width.
   localparam logic [4:0] LW_M1_PW_1  = 5'd31;
   localparam logic [4:0] LW_M1_PW_2  = 5'd15;
   localparam logic [4:0] LW_M1_PW_4  = 5'd7;
   localparam logic [4:0] LW_M1_PW_8  = 5'd3;
   localparam logic [4:0] LW_M1_PW_16 = 5'd1;

   // Multiplier control states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mul_state_t;

   // True when the pack-width encoding names a supported lane width.
   function automatic logic pw_legal(input logic [2:0] pw);
      logic legal;
      case (pw)
         SCARV_COP_PW_1,
         SCARV_COP_PW_2,
         SCARV_COP_PW_4,
         SCARV_COP_PW_8,
         SCARV_COP_PW_16: legal = 1'b1;
         default:         legal = 1'b0;
      endcase
      return legal;
   endfunction

   // Lane width minus one. Because every lane width is a power of two this
   // value doubles as the in-lane bit mask: bit i is a lane LSB when
   // (i & mask) == 0 and a lane MSB when (i & mask) == mask. Illegal
   // encodings fall back to a single 32-bit lane.
   function automatic logic [4:0] lane_width_m1(input logic [2:0] pw);
      logic [4:0] wm1;
      case (pw)
         SCARV_COP_PW_1:  wm1 = LW_M1_PW_1;
         SCARV_COP_PW_2:  wm1 = LW_M1_PW_2;
         SCARV_COP_PW_4:  wm1 = LW_M1_PW_4;
         SCARV_COP_PW_8:  wm1 = LW_M1_PW_8;
         SCARV_COP_PW_16: wm1 = LW_M1_PW_16;
         default:         wm1 = LW_M1_PW_1;
      endcase
      return wm1;
   endfunction

endpackage

// File: rtl/scarv_cop_palu_adder.sv
// Packed adder: adds lhs and rhs lane by lane for the given pack width.
// The carry chain is restarted from ci at every lane LSB, so no carry ever
// crosses from one lane into the next.
module scarv_cop_palu_adder
   import scarv_cop_palu_multiplier_pkg::*;
(
   input  logic [31:0] lhs,
   input  logic [31:0] rhs,
   input  logic [2:0]  pw,
   input  logic        ci,
   output logic [31:0] result
);

   logic [4:0] lane_mask;
   logic       carry;

   // Ripple-carry add across all 32 bits, reloading ci at each lane start.
   always_comb begin
      lane_mask = lane_width_m1(pw);
      carry     = ci;
      result    = '0;
      for (int i = 0; i < 32; i++) begin
         if ((5'(i) & lane_mask) == 5'd0) begin
            carry = ci;
         end
         result[i] = lhs[i] ^ rhs[i] ^ carry;
         carry     = (lhs[i] & rhs[i]) | (carry & (lhs[i] ^ rhs[i]));
      end
   end

endmodule

// File: rtl/scarv_cop_palu_multiplier.sv
// Iterative packed (SIMD) multiplier for the COP packed-arithmetic unit.
// Each lane runs a classic shift-add multiply: the lane's {ACC, B} pair is
// a 2w-bit register, and every step adds the masked multiplicand into ACC
// then shifts the pair right by one. After w steps ACC holds the high half
// and B holds the low half of the exact lane product.
module scarv_cop_palu_multiplier
   import scarv_cop_palu_multiplier_pkg::*;
(
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        start,
   input  logic        flush,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [2:0]  pw,
   input  logic        high,
   output logic        ready,
   output logic        done,
   output logic [31:0] result,
   output logic        bad_pw
);

   mul_state_t  state;
   mul_state_t  state_n;

   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] acc_q;
   logic [2:0]  pw_q;
   logic        high_q;
   logic [4:0]  cnt;

   logic        load;
   logic        step;
   logic        finish;
   logic        illegal;

   logic [4:0]  lane_mask;
   logic [31:0] mcand;
   logic [31:0] sum;
   logic [31:0] sum_shr;
   logic [31:0] b_shr;
   logic [4:0]  lane_lsb;
   logic [31:0] acc_next;
   logic [31:0] b_next;

   // Multiplicand masking: every bit of A is gated by bit 0 of its own B lane.
   always_comb begin
      lane_mask = lane_width_m1(pw_q);
      mcand     = '0;
      for (int i = 0; i < 32; i++) begin
         mcand[i] = a_q[i] & b_q[5'(i) & ~lane_mask];
      end
   end

   scarv_cop_palu_adder u_adder (
      .lhs    (acc_q),
      .rhs    (mcand),
      .pw     (pw_q),
      .ci     (1'b0),
      .result (sum)
   );

   // Per-lane carry recovery and shift: the lane MSB of ACC takes the lost
   // carry-out, the lane MSB of B takes the bit shifted out of the sum's LSB.
   always_comb begin
      sum_shr  = sum >> 1;
      b_shr    = b_q >> 1;
      lane_lsb = '0;
      acc_next = '0;
      b_next   = '0;
      for (int i = 0; i < 32; i++) begin
         lane_lsb = 5'(i) & ~lane_mask;
         if ((5'(i) & lane_mask) == lane_mask) begin
            acc_next[i] = (acc_q[i] & mcand[i]) |
                          ((acc_q[i] | mcand[i]) & ~sum[i]);
            b_next[i]   = sum[lane_lsb];
         end else begin
            acc_next[i] = sum_shr[i];
            b_next[i]   = b_shr[i];
         end
      end
   end

   // Next-state and control decode. flush overrides everything except reset.
   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      illegal = 1'b0;
      if (flush) begin
         state_n = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (pw_legal(pw)) begin
                     load    = 1'b1;
                     state_n = ST_RUN;
                  end else begin
                     illegal = 1'b1;
                     state_n = ST_DONE;
                  end
               end
            end
            ST_RUN: begin
               step = 1'b1;
               if (cnt == 5'd0) begin
                  state_n = ST_DONE;
               end
            end
            ST_DONE: begin
               state_n = ST_IDLE;
            end
            default: begin
               state_n = ST_IDLE;
            end
         endcase
      end
   end

   assign finish = step && (cnt == 5'd0);

   // State register and datapath registers, cleared by synchronous reset.
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state  <= ST_IDLE;
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         pw_q   <= '0;
         high_q <= 1'b0;
         cnt    <= '0;
         result <= '0;
         bad_pw <= 1'b0;
      end else begin
         state <= state_n;
         if (load) begin
            a_q    <= rs1;
            b_q    <= rs2;
            acc_q  <= '0;
            pw_q   <= pw;
            high_q <= high;
            cnt    <= lane_width_m1(pw);
         end
         if (step) begin
            acc_q <= acc_next;
            b_q   <= b_next;
            cnt   <= cnt - 5'd1;
         end
         if (finish) begin
            result <= high_q ? acc_next : b_next;
            bad_pw <= 1'b0;
         end
         if (illegal) begin
            result <= '0;
            bad_pw <= 1'b1;
         end
      end
   end

   assign ready = (state == ST_IDLE);
   assign done  = (state == ST_DONE) && !flush;

endmodule

// File: tb/tb_scarv_cop_palu_multiplier.sv
// Self-checking bench for the packed multiplier. Stimulus pushes expected
// results into a scoreboard; a monitor on the falling edge pops and
// compares result, bad_pw and start-to-done latency whenever done is high.
module tb_scarv_cop_palu_multiplier;
   import scarv_cop_palu_multiplier_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic        bad;
      int          lat;
      int          start_cycle;
      string       name;
   } exp_t;

   logic        g_clk = 1'b0;
   logic        g_reset;
   logic        start;
   logic        flush;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [2:0]  pw;
   logic        high;
   logic        ready;
   logic        done;
   logic [31:0] result;
   logic        bad_pw;

   exp_t        sb[$];
   exp_t        mon_e;
   int          cycle = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   scarv_cop_palu_multiplier dut (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .start   (start),
      .flush   (flush),
      .rs1     (rs1),
      .rs2     (rs2),
      .pw      (pw),
      .high    (high),
      .ready   (ready),
      .done    (done),
      .result  (result),
      .bad_pw  (bad_pw)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 g_clk = ~g_clk;

   // Cycle counter used to measure start-to-done latency.
   always @(posedge g_clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: every done pulse must match the oldest scoreboard entry.
   always @(negedge g_clk) begin
      if (!g_reset && done) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_done", 32'(done), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            checkOutput({mon_e.name, "_result"}, result, mon_e.res);
            checkOutput({mon_e.name, "_bad_pw"}, 32'(bad_pw), 32'(mon_e.bad));
            checkOutput({mon_e.name, "_latency"}, 32'(cycle - mon_e.start_cycle),
                        32'(mon_e.lat));
         end
      end
   end

   task automatic wait_drain(input string name, input int budget);
      for (int k = 0; k < budget; k++) begin
         @(posedge g_clk);
         #2;
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         checkOutput({name, "_timeout"}, 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   // Latency counts the cycle in which start is driven as cycle 0, so done
   // shows up in cycle w+1 (and cycle 1 for an illegal pack width).
   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] p, input logic h,
                        input logic [31:0] res, input logic bad,
                        input int lat, input string name, input logic track);
      @(negedge g_clk);
      rs1   = a;
      rs2   = b;
      pw    = p;
      high  = h;
      start = 1'b1;
      if (track) sb.push_back('{res, bad, lat, cycle, name});
      @(negedge g_clk);
      start = 1'b0;
      rs1   = 32'hDEADBEEF;
      rs2   = 32'h13579BDF;
      pw    = 3'b110;
      high  = ~h;
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] p, input logic h,
                                input logic [31:0] res, input logic bad,
                                input int lat, input string name);
      issue(a, b, p, h, res, bad, lat, name, 1'b1);
      wait_drain(name, lat + 20);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      g_reset = 1'b1;
      start   = 1'b0;
      flush   = 1'b0;
      rs1     = '0;
      rs2     = '0;
      pw      = SCARV_COP_PW_1;
      high    = 1'b0;
      repeat (3) @(negedge g_clk);
      checkOutput("reset_ready", 32'(ready), 32'd1);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_bad_pw", 32'(bad_pw), 32'd0);
      checkOutput("reset_result", result, 32'd0);
      g_reset = 1'b0;

      applyStimulus(32'h00000007, 32'h00000006, SCARV_COP_PW_1, 1'b0, 32'h0000002A, 1'b0, 33, "pw1_7x6_lo");
      applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, SCARV_COP_PW_1, 1'b1, 32'hFFFFFFFE, 1'b0, 33, "pw1_ones_hi");
      applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, SCARV_COP_PW_1, 1'b0, 32'h00000001, 1'b0, 33, "pw1_ones_lo");
      applyStimulus(32'h0203FF10, 32'h0305FF10, SCARV_COP_PW_4, 1'b0, 32'h060F0100, 1'b0, 9, "pw4_lo");
      applyStimulus(32'h0203FF10, 32'h0305FF10, SCARV_COP_PW_4, 1'b1, 32'h0000FE01, 1'b0, 9, "pw4_hi");
      applyStimulus(32'h00030100, 32'h00050100, SCARV_COP_PW_2, 1'b0, 32'h000F0000, 1'b0, 17, "pw2_lo");
      applyStimulus(32'h00030100, 32'h00050100, SCARV_COP_PW_2, 1'b1, 32'h00000001, 1'b0, 17, "pw2_hi");
      applyStimulus(32'h0000000F, 32'hFFFFFFFF, SCARV_COP_PW_8, 1'b0, 32'h00000001, 1'b0, 5, "pw8_lo");
      applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, SCARV_COP_PW_16, 1'b0, 32'h55555555, 1'b0, 3, "pw16_lo");
      applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, SCARV_COP_PW_16, 1'b1, 32'hAAAAAAAA, 1'b0, 3, "pw16_hi");
      applyStimulus(32'h12345678, 32'h9ABCDEF0, 3'b111, 1'b0, 32'h00000000, 1'b1, 1, "illegal_111");
      applyStimulus(32'h12345678, 32'h9ABCDEF0, 3'b000, 1'b1, 32'h00000000, 1'b1, 1, "illegal_000");

      // A start pulse during RUN must not disturb or queue behind the operation.
      issue(32'h0203FF10, 32'h0305FF10, SCARV_COP_PW_4, 1'b0, 32'h060F0100, 1'b0, 9, "ignored_start", 1'b1);
      repeat (2) @(negedge g_clk);
      checkOutput("ready_in_run", 32'(ready), 32'd0);
      rs1   = 32'h00000000;
      rs2   = 32'h00000000;
      pw    = SCARV_COP_PW_1;
      start = 1'b1;
      @(negedge g_clk);
      start = 1'b0;
      wait_drain("ignored_start", 30);
      repeat (40) @(negedge g_clk);

      applyStimulus(32'h0000000F, 32'hFFFFFFFF, SCARV_COP_PW_8, 1'b1, 32'h0000000E, 1'b0, 5, "pw8_hi");

      // Flush in the fifth RUN cycle: back to IDLE, no done, result kept.
      issue(32'h00000007, 32'h00000006, SCARV_COP_PW_1, 1'b0, 32'h0, 1'b0, 0, "flush", 1'b0);
      repeat (4) @(negedge g_clk);
      flush = 1'b1;
      @(negedge g_clk);
      flush = 1'b0;
      checkOutput("flush_ready", 32'(ready), 32'd1);
      checkOutput("flush_done", 32'(done), 32'd0);
      checkOutput("flush_result", result, 32'h0000000E);
      repeat (40) @(negedge g_clk);
      checkOutput("flush_result_later", result, 32'h0000000E);

      // Reset in the middle of RUN discards the operation entirely.
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, SCARV_COP_PW_1, 1'b1, 32'h0, 1'b0, 0, "reset_run", 1'b0);
      repeat (3) @(negedge g_clk);
      g_reset = 1'b1;
      @(negedge g_clk);
      checkOutput("rst_run_ready", 32'(ready), 32'd1);
      checkOutput("rst_run_done", 32'(done), 32'd0);
      checkOutput("rst_run_result", result, 32'd0);
      g_reset = 1'b0;
      repeat (40) @(negedge g_clk);

      applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, SCARV_COP_PW_16, 1'b1, 32'hAAAAAAAA, 1'b0, 3, "after_reset");

      repeat (5) @(negedge g_clk);
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/scarv_cop_palu_multiplier.md
Name: scarv_cop_palu_multiplier

Overview:
- Iterative packed (SIMD) multiplier for the COP packed-arithmetic unit.
- Multiplies each lane of rs1 by the matching lane of rs2 for pack widths of 32/16/8/4/2 bits.
- Returns either the low or the high half of every lane product.
- Sits directly upstream of the packed adder: each cycle it drives one packed add (accumulator + masked multiplicand) and consumes the sum to shift-accumulate the partial product.

Parameters:
- None. Datapath is fixed at 32 bits; pack-width encodings come from the shared COP constants.

Ports:
- g_clk      in   1   clock; all state updates on rising edge
- g_reset    in   1   synchronous, active-high reset
- start      in   1   request; sampled only when ready=1
- flush      in   1   abort current operation; return to IDLE
- rs1        in   32  multiplicand (packed lanes)
- rs2        in   32  multiplier (packed lanes)
- pw         in   3   pack width (SCARV_COP_PW_1/2/4/8/16)
- high       in   1   0: return low half of each lane product; 1: return high half
- ready      out  1   block idle and able to accept start
- done       out  1   one-cycle pulse; result valid
- result     out  32  packed result; held stable until the next accepted start
- bad_pw     out  1   with done: pw was not a legal encoding

Behaviour:
- Interface: one clock (g_clk); reset g_reset is synchronous, active-high.
- Reset: state=IDLE, ready=1, done=0, bad_pw=0, result=0, all internal registers 0. Reset mid-operation discards the operation; no done is produced.
- Lane width w: PW_1=32, PW_2=16, PW_4=8, PW_8=4, PW_16=2.
- States: IDLE, RUN, DONE.
- IDLE (ready=1):
  - On start with a legal pw: latch A=rs1, B=rs2, ACC=0, pw, high, cnt=w-1; go RUN.
  - On start with an illegal pw: result=0, bad_pw=1; go DONE. No steps are performed.
- RUN (ready=0). One step per cycle:
  - M = A AND lane-replicated bit0 of each B lane.
  - S = packed_add(ACC, M, pw, ci=0); lane carries are blocked at lane boundaries.
  - Lane carry-out k = (ACC_msb & M_msb) | ((ACC_msb | M_msb) & ~S_msb), taken per lane MSB.
  - Per lane: ACC_lane = {k, S_lane[w-1:1]}; B_lane = {S_lane[0], B_lane[w-1:1]}.
  - When the step is taken with cnt==0: result = high ? ACC_next : B_next, bad_pw=0; go DONE. Otherwise cnt decrements.
- DONE: done=1 for exactly one cycle, ready=0; then go IDLE.
- Latency: start sampled at edge 0; steps at edges 1..w; done high in the cycle after edge w. Start-to-next-start is therefore w+2 cycles minimum.
- start while ready=0 is ignored; there is no queuing.
- flush has priority over start and over stepping:
  - Any state goes to IDLE next edge.
  - done is not asserted; result retains its previous value.
- g_reset has priority over flush.
- Unsigned arithmetic only. Lane products are exact (2w bits split as high/low); no overflow or saturation.
- Operands are latched on start; rs1, rs2, pw and high may change freely during RUN.

Decomposition:
- Shared header (scarv_cop_common.vh):
  - SCARV_COP_PW_* encodings, already in use.
  - New state constants for IDLE/RUN/DONE.
  - A lane-width-minus-one lookup constant per PW.
- Sub-module: instantiate the existing packed adder scarv_cop_palu_adder for the S computation (ci tied 0).
- Lane masking, per-lane carry recovery and per-lane shift are local generate logic.

Test Plan:
- pw=PW_1, rs1=0x00000007, rs2=0x00000006, high=0 -> done exactly 33 cycles after the start edge; result=0x0000002A.
- pw=PW_1, rs1=rs2=0xFFFFFFFF:
  - high=1 -> result=0xFFFFFFFE.
  - Repeated with high=0 -> result=0x00000001.
- pw=PW_4, rs1=0x0203FF10, rs2=0x0305FF10:
  - high=0 -> result=0x060F0100.
  - high=1 -> result=0x0000FE01.
  - done 9 cycles after start.
- pw=PW_16, rs1=rs2=0xFFFFFFFF:
  - high=0 -> 0x55555555.
  - high=1 -> 0xAAAAAAAA.
  - done 3 cycles after start.
- Illegal pw=3'b111 with start -> done next cycle with bad_pw=1, result=0.
- Control interactions:
  - start during RUN is ignored.
  - flush in the 5th RUN cycle of PW_1 -> IDLE next cycle, no done, result unchanged.
  - g_reset during RUN -> ready=1 and done=0 next cycle.
